// File: rtl/instr_encoder_if.sv
// Field-set input stream and encoded-word output stream of the instruction encoder.
// The slave side is the encoder; the master side is the program source and memory loader.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [3:0]        in_rdest;
    logic [3:0]        in_rsrc;
    logic [15:0]       in_imm;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_instr;
    logic              out_last;

    modport master (
        output in_valid,
        input  in_ready,
        output in_opcode,
        output in_rdest,
        output in_rsrc,
        output in_imm,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_instr,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_opcode,
        input  in_rdest,
        input  in_rsrc,
        input  in_imm,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_instr,
        output out_last
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit words and streams them with their
// instruction-memory addresses, flagging bad opcodes, oversized immediates and address overflow.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    instr_encoder_if.slave    bus,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_BAD,
        CLS_RPJ,
        CLS_I8,
        CLS_SHIFT
    } op_class_t;

    state_t            state;
    state_t            state_next;
    op_class_t         op_class;

    logic [3:0]        op_hi;
    logic [3:0]        op_lo;
    logic              fits_i8;
    logic              fits_shift;
    logic              field_ok;
    logic [1:0]        field_err;
    logic [15:0]       word;

    logic [ADDR_W-1:0] addr;
    logic              addr_max;
    logic              in_ready;
    logic              accept;

    logic              out_valid;
    logic              out_last;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_instr;

    assign op_hi      = bus.in_opcode[7:4];
    assign op_lo      = bus.in_opcode[3:0];
    assign fits_i8    = (&bus.in_imm[15:7]) | ~(|bus.in_imm[15:7]);
    assign fits_shift = (&bus.in_imm[15:4]) | ~(|bus.in_imm[15:4]);
    assign addr_max   = &addr;

    // Opcode map: the decoder's three word layouts, everything else is illegal.
    always_comb begin
        op_class = CLS_BAD;
        case (op_hi)
            4'h0: begin
                if (op_lo <= 4'h9 || op_lo == 4'hB || op_lo == 4'hF) begin
                    op_class = CLS_RPJ;
                end
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC: begin
                op_class = CLS_I8;
            end
            4'h4: begin
                if (op_lo[1:0] == 2'b00) begin
                    op_class = CLS_RPJ;
                end
            end
            4'h8: begin
                case (op_lo[3:2])
                    2'b00, 2'b10: op_class = CLS_SHIFT;
                    2'b01:        op_class = CLS_RPJ;
                    default:      op_class = CLS_BAD;
                endcase
            end
            default: op_class = CLS_BAD;
        endcase
    end

    always_comb begin
        word      = 16'h0000;
        field_ok  = 1'b0;
        field_err = 2'b01;
        case (op_class)
            CLS_RPJ: begin
                word     = {op_hi, bus.in_rdest, op_lo, bus.in_rsrc};
                field_ok = 1'b1;
            end
            CLS_I8: begin
                word      = {op_hi, bus.in_rdest, bus.in_imm[7:0]};
                field_ok  = fits_i8;
                field_err = 2'b10;
            end
            CLS_SHIFT: begin
                word      = {4'b1000, bus.in_rdest, op_lo[3:1], bus.in_imm[4:0]};
                field_ok  = fits_shift;
                field_err = 2'b10;
            end
            default: begin
                word      = 16'h0000;
                field_ok  = 1'b0;
                field_err = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A valid word landing on the last address ends the load just like in_last.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || bus.out_ready;
                if (in_ready && bus.in_valid && (bus.in_last || (field_ok && addr_max))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || bus.out_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept       = bus.in_valid & in_ready;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_addr  <= '0;
            out_instr <= 16'h0000;
            err_valid <= 1'b0;
            err_code  <= 2'b00;
            err_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            done      <= (state_next == DONE);
            busy      <= (state_next != IDLE);

            if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE && start) begin
                addr  <= base_addr;
                count <= '0;
            end

            // Rejected field sets leave addr and count alone so the next word reuses the slot.
            if (accept) begin
                if (field_ok) begin
                    out_valid <= 1'b1;
                    out_addr  <= addr;
                    out_instr <= word;
                    out_last  <= bus.in_last | addr_max;
                    count     <= count + 1'b1;
                    if (!addr_max) begin
                        addr <= addr + 1'b1;
                    end
                    if (addr_max && !bus.in_last) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b11;
                        err_addr  <= addr;
                    end
                end else begin
                    err_valid <= 1'b1;
                    err_code  <= field_err;
                    err_addr  <= addr;
                end
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_addr  = out_addr;
    assign bus.out_instr = out_instr;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a transaction-level model predicts words, errors
// and load completion; a negedge monitor compares whatever the encoder presents.
module tb_instr_encoder;

    localparam int ADDR_W = 8;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        last;
    } field_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] instr;
        logic        last;
    } word_t;

    typedef struct {
        logic [1:0] code;
        logic [7:0] addr;
    } err_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] err_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    int     checks = 0;
    int     errors = 0;
    int     done_seen = 0;
    int     ready_mode = 0;

    field_t prog[$];
    word_t  exp_words[$];
    err_t   exp_errs[$];
    int     exp_done[$];

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus_if ();

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus_if),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_addr  (err_addr),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic note_failure(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference model: opcode classes straight from the decoder's opcode table.
    function automatic int op_class(input logic [7:0] op);
        if (op inside {[8'h00:8'h09], 8'h0B, 8'h0F, 8'h40, 8'h44, 8'h48, 8'h4C, [8'h84:8'h87]}) return 1;
        if (op[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC}) return 2;
        if (op inside {[8'h80:8'h83], [8'h88:8'h8B]}) return 3;
        return 0;
    endfunction

    // Walks the program at transaction level; returns how many field sets the encoder will take.
    function automatic int model_load(input logic [7:0] base);
        int    a;
        int    n_words;
        a       = int'(base);
        n_words = 0;
        for (int i = 0; i < prog.size(); i++) begin
            int    cls;
            int    v;
            int    hi;
            int    lo;
            int    code;
            int    w;
            word_t ew;
            err_t  ee;
            cls  = op_class(prog[i].op);
            v    = int'($signed(prog[i].imm));
            hi   = int'(prog[i].op) / 16;
            lo   = int'(prog[i].op) % 16;
            code = 0;
            w    = 0;
            case (cls)
                1: w = hi * 4096 + int'(prog[i].rd) * 256 + lo * 16 + int'(prog[i].rs);
                2: if (v < -128 || v > 127) code = 2;
                   else w = hi * 4096 + int'(prog[i].rd) * 256 + (v & 255);
                3: if (v < -16 || v > 15) code = 2;
                   else w = 32768 + int'(prog[i].rd) * 256 + (lo / 2) * 32 + (v & 31);
                default: code = 1;
            endcase
            if (code != 0) begin
                ee.code = 2'(code);
                ee.addr = 8'(a);
                exp_errs.push_back(ee);
                if (prog[i].last) begin
                    exp_done.push_back(n_words);
                    return i + 1;
                end
            end else begin
                ew.addr  = 8'(a);
                ew.instr = 16'(w);
                ew.last  = prog[i].last || (a == 255);
                exp_words.push_back(ew);
                n_words++;
                if (a == 255 && !prog[i].last) begin
                    ee.code = 2'b11;
                    ee.addr = 8'hFF;
                    exp_errs.push_back(ee);
                    exp_done.push_back(n_words);
                    return i + 1;
                end
                if (prog[i].last) begin
                    exp_done.push_back(n_words);
                    return i + 1;
                end
                a++;
            end
        end
        exp_done.push_back(n_words);
        return prog.size();
    endfunction

    task automatic add_set(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [15:0] imm, input logic last);
        field_t f;
        f.op = op; f.rd = rd; f.rs = rs; f.imm = imm; f.last = last;
        prog.push_back(f);
    endtask

    task automatic drive_fields(input field_t f);
        bus_if.in_opcode = f.op;
        bus_if.in_rdest  = f.rd;
        bus_if.in_rsrc   = f.rs;
        bus_if.in_imm    = f.imm;
        bus_if.in_last   = f.last;
    endtask

    // Presents one field set and holds it until the encoder takes it.
    task automatic apply_stimulus(input field_t f);
        int waited;
        waited = 0;
        drive_fields(f);
        bus_if.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus_if.in_ready) break;
            waited++;
            if (waited > 200) begin
                note_failure("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] base, input bit gaps);
        int n;
        int waited;
        int done_before;
        n = model_load(base);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start     = 1'b0;
        done_before = done_seen;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(prog[i]);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        if (n < prog.size()) begin
            drive_fields(prog[n]);
            bus_if.in_valid = 1'b1;
        end
        waited = 0;
        while (done_seen == done_before && waited < 500) begin
            @(negedge clk); #1;
            if (n < prog.size()) check_output("in_ready_after_end", 32'(bus_if.in_ready), 0);
            waited++;
        end
        if (done_seen == done_before) note_failure("done_timeout");
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        check_output("busy_after_done", 32'(busy), 0);
        check_output("words_left", 32'(exp_words.size()), 0);
        check_output("errs_left", 32'(exp_errs.size()), 0);
        exp_words.delete();
        exp_errs.delete();
        exp_done.delete();
        prog.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"},  32'(bus_if.in_ready), 0);
        check_output({tag, "_out_valid"}, 32'(bus_if.out_valid), 0);
        check_output({tag, "_out_last"},  32'(bus_if.out_last), 0);
        check_output({tag, "_out_addr"},  32'(bus_if.out_addr), 0);
        check_output({tag, "_out_instr"}, 32'(bus_if.out_instr), 0);
        check_output({tag, "_err_valid"}, 32'(err_valid), 0);
        check_output({tag, "_err_code"},  32'(err_code), 0);
        check_output({tag, "_err_addr"},  32'(err_addr), 0);
        check_output({tag, "_busy"},      32'(busy), 0);
        check_output({tag, "_done"},      32'(done), 0);
        check_output({tag, "_count"},     32'(count), 0);
    endtask

    task automatic build_random_prog(input int len);
        logic [7:0] r_ops [11] = '{8'h00, 8'h05, 8'h09, 8'h0B, 8'h0F, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h84, 8'h87};
        prog.delete();
        for (int i = 0; i < len; i++) begin
            field_t f;
            case ($urandom_range(0, 3))
                0:       f.op = 8'($urandom);
                1:       f.op = 8'h80 + 8'($urandom_range(0, 15));
                2:       f.op = r_ops[$urandom_range(0, 10)];
                default: f.op = 8'($urandom_range(1, 12) * 16 + $urandom_range(0, 15));
            endcase
            f.rd   = 4'($urandom);
            f.rs   = 4'($urandom);
            f.imm  = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(0, 300)) - 16'd150 : 16'($urandom);
            f.last = (i == len - 1);
            prog.push_back(f);
        end
    endtask

    initial begin
        bus_if.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = 1'($urandom_range(0, 1));
                default: bus_if.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, error pulse and done pulse.
    initial begin
        logic        prev_stall;
        logic        prev_done;
        logic [7:0]  held_addr;
        logic [15:0] held_instr;
        logic        held_last;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        held_addr  = '0;
        held_instr = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_output("hold_out_valid", 32'(bus_if.out_valid), 1);
                    check_output("hold_out_addr",  32'(bus_if.out_addr), 32'(held_addr));
                    check_output("hold_out_instr", 32'(bus_if.out_instr), 32'(held_instr));
                    check_output("hold_out_last",  32'(bus_if.out_last), 32'(held_last));
                end
                if (bus_if.out_valid && !bus_if.out_ready) begin
                    check_output("in_ready_while_full", 32'(bus_if.in_ready), 0);
                    held_addr  = bus_if.out_addr;
                    held_instr = bus_if.out_instr;
                    held_last  = bus_if.out_last;
                    prev_stall = 1'b1;
                end else begin
                    prev_stall = 1'b0;
                end
                if (bus_if.out_valid && bus_if.out_ready) begin
                    if (exp_words.size() == 0) begin
                        note_failure("unexpected_word");
                    end else begin
                        word_t ew;
                        ew = exp_words.pop_front();
                        check_output("word_addr",  32'(bus_if.out_addr), 32'(ew.addr));
                        check_output("word_instr", 32'(bus_if.out_instr), 32'(ew.instr));
                        check_output("word_last",  32'(bus_if.out_last), 32'(ew.last));
                    end
                end
                if (err_valid) begin
                    if (exp_errs.size() == 0) begin
                        note_failure("unexpected_error");
                    end else begin
                        err_t ee;
                        ee = exp_errs.pop_front();
                        check_output("err_code", 32'(err_code), 32'(ee.code));
                        check_output("err_addr", 32'(err_addr), 32'(ee.addr));
                    end
                end
                if (done) begin
                    check_output("done_single_cycle", 32'(prev_done), 0);
                    if (exp_done.size() == 0) begin
                        note_failure("unexpected_done");
                    end else begin
                        check_output("done_count", 32'(count), 32'(exp_done.pop_front()));
                    end
                    done_seen++;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_opcode = '0;
        bus_if.in_rdest  = '0;
        bus_if.in_rsrc   = '0;
        bus_if.in_imm    = '0;
        bus_if.in_last   = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;

        $display("[TB] basic two-word load");
        ready_mode = 0;
        add_set(8'h05, 4'd1, 4'd2, 16'h0000, 1'b0);
        add_set(8'h40, 4'd1, 4'd0, 16'h0000, 1'b1);
        run_load(8'h10, 1'b0);
        check_output("basic_count", 32'(count), 2);

        $display("[TB] immediate and shift encodings");
        ready_mode = 1;
        add_set(8'h50, 4'd3, 4'd0, 16'hFFFB, 1'b0);
        add_set(8'h80, 4'd2, 4'd0, 16'h0003, 1'b0);
        add_set(8'h8A, 4'd4, 4'd0, 16'hFFFF, 1'b1);
        run_load(8'h30, 1'b0);

        $display("[TB] rejected field sets");
        add_set(8'h50, 4'd1, 4'd0, 16'd200, 1'b0);
        add_set(8'h0D, 4'd1, 4'd2, 16'h0000, 1'b0);
        add_set(8'h0B, 4'd1, 4'd2, 16'h0000, 1'b1);
        run_load(8'h40, 1'b0);

        $display("[TB] downstream stall");
        for (int i = 0; i < 6; i++) add_set(8'h01 + 8'(i), 4'(i), 4'(i + 3), 16'h0000, i == 5);
        fork
            run_load(8'h60, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #2 ready_mode = 2;
                repeat (5) @(posedge clk);
                #2 ready_mode = 1;
            end
        join

        $display("[TB] address overflow");
        ready_mode = 0;
        add_set(8'h05, 4'd1, 4'd2, 16'h0000, 1'b0);
        add_set(8'h06, 4'd3, 4'd4, 16'h0000, 1'b0);
        add_set(8'h07, 4'd5, 4'd6, 16'h0000, 1'b0);
        run_load(8'hFE, 1'b0);
        check_output("overflow_count", 32'(count), 2);

        $display("[TB] random loads");
        ready_mode = 1;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] base;
            base = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
            build_random_prog($urandom_range(1, 12));
            run_load(base, 1'b1);
        end

        $display("[TB] reset during a load");
        ready_mode = 2;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 8'h20;
        @(posedge clk); #1;
        start     = 1'b0;
        add_set(8'h05, 4'd7, 4'd8, 16'h0000, 1'b0);
        apply_stimulus(prog[0]);
        prog.delete();
        check_output("pending_out_valid", 32'(bus_if.out_valid), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_values("midload_reset");
        reset = 1'b1;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("no_restart_busy", 32'(busy), 0);
        check_output("no_restart_out_valid", 32'(bus_if.out_valid), 0);
        add_set(8'h0F, 4'd2, 4'd9, 16'h0000, 1'b1);
        run_load(8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
